// File: rtl/fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage : RV32I instruction fetch + IF/DE register, stall/flush stats
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      de_pc,
  output logic [31:0]      de_pc4,
  output logic [31:0]      de_instr,
  output logic             de_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             misalign
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STALL    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      de_pc_q, de_pc_d;
  logic [31:0]      de_pc4_q, de_pc4_d;
  logic [31:0]      de_instr_q, de_instr_d;
  logic             de_valid_q, de_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             misalign_q, misalign_d;
  logic [31:0]      pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect outranks a stall; BOOT fetches exactly like RUN.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    de_pc_d     = de_pc_q;
    de_pc4_d    = de_pc4_q;
    de_instr_d  = de_instr_q;
    de_valid_d  = de_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    misalign_d  = misalign_q;
    if (br_taken) begin
      pc_d        = br_target & ~32'h3;
      de_pc_d     = 32'h0;
      de_pc4_d    = 32'h0;
      de_instr_d  = NOP;
      de_valid_d  = 1'b0;
      flush_cnt_d = (flush_cnt_q == CNT_MAX) ? flush_cnt_q : flush_cnt_q + CNT_ONE;
      misalign_d  = misalign_q | (br_target[1:0] != 2'b00);
      state_d     = ST_REDIRECT;
    end else if (!enable) begin
      stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_ONE;
      state_d     = ST_STALL;
    end else begin
      de_pc_d    = pc_q;
      de_pc4_d   = pc_plus4;
      de_instr_d = imem_instr;
      de_valid_d = 1'b1;
      pc_d       = pc_plus4;
      state_d    = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      de_pc_q     <= 32'h0;
      de_pc4_q    <= 32'h0;
      de_instr_q  <= NOP;
      de_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      de_pc_q     <= de_pc_d;
      de_pc4_q    <= de_pc4_d;
      de_instr_q  <= de_instr_d;
      de_valid_q  <= de_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  assign imem_addr = pc_q;
  assign de_pc     = de_pc_q;
  assign de_pc4    = de_pc4_q;
  assign de_instr  = de_instr_q;
  assign de_valid  = de_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign misalign  = misalign_q;

endmodule
`default_nettype wire
